// File: rtl/bus_frame_pkg.sv
// bus_frame_pkg
// Shared definitions for the byte-serial bus frame target: phase numbering of
// the 11-phase frame, frame length, transaction state encoding and the phase
// sequencing rule used by both the counter and the registered read-return path.
package bus_frame_pkg;

    localparam int FRAME_LEN = 11;

    localparam logic [3:0] PH_SYNC = 4'd0;
    localparam logic [3:0] PH_A0   = 4'd1;
    localparam logic [3:0] PH_A1   = 4'd2;
    localparam logic [3:0] PH_A2   = 4'd3;
    localparam logic [3:0] PH_A3   = 4'd4;
    localparam logic [3:0] PH_RW   = 4'd5;
    localparam logic [3:0] PH_D0   = 4'd6;
    localparam logic [3:0] PH_D1   = 4'd7;
    localparam logic [3:0] PH_D2   = 4'd8;
    localparam logic [3:0] PH_D3   = 4'd9;
    localparam logic [3:0] PH_IDLE = 4'd10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2
    } txn_state_t;

    // frame_sync always lands the frame in P1 on the following cycle, which is
    // why a sync pulse during P0 changes nothing.
    function automatic logic [3:0] next_phase(input logic [3:0] cur, input logic sync);
        logic [3:0] nxt;
        if (sync) begin
            nxt = PH_A0;
        end else if (cur == 4'(FRAME_LEN - 1)) begin
            nxt = PH_SYNC;
        end else begin
            nxt = cur + 4'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/frame_phase_counter.sv
// frame_phase_counter
// Tracks the current phase (P0..P10) of the byte-serial bus frame.
// Ports:
//   clk        - clock, rising edge
//   rst_n      - synchronous active-low reset, returns phase to P0
//   frame_sync - resynchronises the frame: phase becomes P1 next cycle
//   phase      - current frame phase
module frame_phase_counter
    import bus_frame_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_sync,
    output logic [3:0] phase
);

    logic [3:0] phase_d;
    logic [3:0] phase_q;

    always_comb begin
        phase_d = next_phase(phase_q, frame_sync);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q <= PH_SYNC;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/bus_frame_target.sv
// bus_frame_target
// Bus-side target for the CPU handler's byte-serial bus. Each 11-phase frame
// carries a 32-bit address, 32-bit write data and an rw flag (P1..P5) and
// returns 32 bits of read data (P6..P9). Every frame performs a speculative
// read in P5; frames flagged as writes then issue the write from P6 on.
// Ports:
//   clk, rst_n            - clock and synchronous active-low reset
//   frame_sync            - marks P0, forces phase P1 next cycle
//   bus_addr, bus_wdata   - address / write-data bytes (LSB first), rw flag in P5
//   bus_rdata, bus_rdata_oe - read-data bytes driven in P6..P9
//   mem_req .. mem_ack    - single-outstanding req/ack memory port
//   err                   - sticky timeout flag
//   phase                 - current frame phase (debug)
module bus_frame_target
    import bus_frame_pkg::*;
#(
    parameter logic [31:0] TIMEOUT_FILL = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_sync,
    input  logic [7:0]  bus_addr,
    input  logic [7:0]  bus_wdata,
    output logic [7:0]  bus_rdata,
    output logic        bus_rdata_oe,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        err,
    output logic [3:0]  phase
);

    logic [3:0]  phase_next;

    txn_state_t  state_d, state_q;
    logic [31:0] addr_buf_d, addr_buf_q;
    logic [31:0] wdata_buf_d, wdata_buf_q;
    logic        we_buf_d, we_buf_q;
    logic [31:0] rbuf_d, rbuf_q;
    logic        mem_req_d, mem_req_q;
    logic        mem_we_d, mem_we_q;
    logic [31:0] mem_addr_d, mem_addr_q;
    logic [31:0] mem_wdata_d, mem_wdata_q;
    logic        err_d, err_q;
    logic [7:0]  bus_rdata_d, bus_rdata_q;
    logic        bus_rdata_oe_d, bus_rdata_oe_q;

    frame_phase_counter u_phase (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_sync (frame_sync),
        .phase      (phase)
    );

    // The read-return byte is registered, so it is chosen from the phase the
    // frame is about to enter rather than the current one.
    assign phase_next = next_phase(phase, frame_sync);

    always_comb begin
        state_d        = state_q;
        addr_buf_d     = addr_buf_q;
        wdata_buf_d    = wdata_buf_q;
        we_buf_d       = we_buf_q;
        rbuf_d         = rbuf_q;
        mem_req_d      = mem_req_q;
        mem_we_d       = mem_we_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        err_d          = err_q;
        bus_rdata_d    = 8'h00;
        bus_rdata_oe_d = 1'b0;

        case (phase)
            PH_A0: begin
                addr_buf_d[7:0]   = bus_addr;
                wdata_buf_d[7:0]  = bus_wdata;
            end
            PH_A1: begin
                addr_buf_d[15:8]  = bus_addr;
                wdata_buf_d[15:8] = bus_wdata;
            end
            PH_A2: begin
                addr_buf_d[23:16]  = bus_addr;
                wdata_buf_d[23:16] = bus_wdata;
            end
            PH_A3: begin
                addr_buf_d[31:24]  = bus_addr;
                wdata_buf_d[31:24] = bus_wdata;
            end
            PH_RW:   we_buf_d = bus_addr[0];
            default: ;
        endcase

        // A frame_sync while a request is open abandons it silently; timeouts
        // are the only source of err.
        case (state_q)
            IDLE: begin
                // The last address byte lands on this same edge, so the
                // request uses the freshly packed address.
                if (phase_next == PH_RW) begin
                    state_d    = RD_WAIT;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = addr_buf_d;
                end
            end
            RD_WAIT: begin
                if (frame_sync) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                end else begin
                    if (mem_ack) begin
                        rbuf_d = mem_rdata;
                    end else begin
                        rbuf_d = TIMEOUT_FILL;
                        err_d  = 1'b1;
                    end
                    if (we_buf_d) begin
                        state_d     = WR_WAIT;
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = addr_buf_q;
                        mem_wdata_d = wdata_buf_q;
                    end else begin
                        state_d   = IDLE;
                        mem_req_d = 1'b0;
                    end
                end
            end
            WR_WAIT: begin
                if (frame_sync || mem_ack) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                end else if (phase == PH_IDLE) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase

        case (phase_next)
            PH_D0:   bus_rdata_d = rbuf_d[7:0];
            PH_D1:   bus_rdata_d = rbuf_d[15:8];
            PH_D2:   bus_rdata_d = rbuf_d[23:16];
            PH_D3:   bus_rdata_d = rbuf_d[31:24];
            default: bus_rdata_d = 8'h00;
        endcase
        bus_rdata_oe_d = (phase_next >= PH_D0) && (phase_next <= PH_D3);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            addr_buf_q     <= '0;
            wdata_buf_q    <= '0;
            we_buf_q       <= 1'b0;
            rbuf_q         <= '0;
            mem_req_q      <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            err_q          <= 1'b0;
            bus_rdata_q    <= 8'h00;
            bus_rdata_oe_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            addr_buf_q     <= addr_buf_d;
            wdata_buf_q    <= wdata_buf_d;
            we_buf_q       <= we_buf_d;
            rbuf_q         <= rbuf_d;
            mem_req_q      <= mem_req_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            err_q          <= err_d;
            bus_rdata_q    <= bus_rdata_d;
            bus_rdata_oe_q <= bus_rdata_oe_d;
        end
    end

    assign bus_rdata    = bus_rdata_q;
    assign bus_rdata_oe = bus_rdata_oe_q;
    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign err          = err_q;

endmodule

// File: tb/tb_bus_frame_target.sv
// tb_bus_frame_target
// Drives whole bus frames into bus_frame_target and plays the memory side.
// For every cycle the expected outputs are derived from the frame's contents
// (address, data, rw flag, when memory acks) and compared on the falling edge.
module tb_bus_frame_target;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_sync;
    logic [7:0]  bus_addr;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata;
    logic        bus_rdata_oe;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        err;
    logic [3:0]  phase;

    int tests_run    = 0;
    int tests_failed = 0;

    logic        chk_en = 1'b0;
    logic [3:0]  e_phase;
    logic [7:0]  e_rdata;
    logic        e_oe, e_req, e_we, e_err;
    logic [31:0] e_addr, e_wdata;

    logic        m_err;
    logic [31:0] last_addr, last_wdata;
    logic        last_we;

    logic [31:0] snap_rdata [0:15];
    logic [31:0] snap_addr  [0:15];
    logic [31:0] snap_wdata [0:15];
    logic [31:0] snap_we    [0:15];
    logic [31:0] snap_req   [0:15];
    logic [31:0] snap_oe    [0:15];

    bus_frame_target dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_sync   (frame_sync),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_rdata    (bus_rdata),
        .bus_rdata_oe (bus_rdata_oe),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack),
        .err          (err),
        .phase        (phase)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the frame model, plus a snapshot by phase
    // so literal checks can be made once a frame is over.
    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("phase",        32'(phase),        32'(e_phase));
            checkOutput("bus_rdata",    32'(bus_rdata),    32'(e_rdata));
            checkOutput("bus_rdata_oe", 32'(bus_rdata_oe), 32'(e_oe));
            checkOutput("mem_req",      32'(mem_req),      32'(e_req));
            checkOutput("mem_we",       32'(mem_we),       32'(e_we));
            checkOutput("mem_addr",     mem_addr,          e_addr);
            checkOutput("mem_wdata",    mem_wdata,         e_wdata);
            checkOutput("err",          32'(err),          32'(e_err));
            snap_rdata[e_phase] = 32'(bus_rdata);
            snap_addr[e_phase]  = mem_addr;
            snap_wdata[e_phase] = mem_wdata;
            snap_we[e_phase]    = 32'(mem_we);
            snap_req[e_phase]   = 32'(mem_req);
            snap_oe[e_phase]    = 32'(bus_rdata_oe);
        end
    end

    // Runs one frame from start_ph. wr_ack_ph < 0 means the write is never
    // acked; sync_ph / rst_ph (>= 0) cut the frame short after that phase with
    // a frame_sync or a reset; late_ack pulses mem_ack in P0.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] rdata, input logic we, input logic rd_ack,
                                 input int wr_ack_ph, input int start_ph, input int sync_ph,
                                 input int rst_ph, input logic late_ack);
        logic [31:0] ret;
        logic [31:0] p_addr;
        logic [31:0] p_wdata;
        logic        p_we;
        int          wend;
        int          last_p;
        ret     = rd_ack ? rdata : 32'hFFFF_FFFF;
        wend    = (wr_ack_ph >= 6) ? wr_ack_ph : 10;
        p_addr  = last_addr;
        p_wdata = last_wdata;
        p_we    = last_we;
        last_p  = start_ph;
        for (int p = start_ph; p <= 10; p++) begin
            rst_n      = (p != rst_ph);
            frame_sync = (p == 0) || (p == sync_ph);
            bus_addr   = 8'hA5;
            bus_wdata  = 8'h5A;
            if (p >= 1 && p <= 4) begin
                bus_addr  = addr[8*(p-1) +: 8];
                bus_wdata = wdata[8*(p-1) +: 8];
            end
            if (p == 5) bus_addr = {7'b1010101, we};
            mem_rdata = rdata;
            mem_ack   = (p == 5 && rd_ack) || (we && p == wr_ack_ph) || (p == 0 && late_ack);

            e_phase = 4'(p);
            e_oe    = (p >= 6 && p <= 9);
            if (e_oe) e_rdata = ret[8*(p-6) +: 8];
            else      e_rdata = 8'h00;
            e_req   = (p == 5) || (we && p >= 6 && p <= wend);
            e_we    = (p < 5) ? p_we : ((p == 5) ? 1'b0 : we);
            e_addr  = (p < 5) ? p_addr : addr;
            e_wdata = (p >= 6 && we) ? wdata : p_wdata;
            if (p == 6 && !rd_ack) m_err = 1'b1;
            e_err   = m_err;
            chk_en  = 1'b1;
            last_p  = p;
            @(posedge clk);
            #1;
            if (p == sync_ph || p == rst_ph) break;
        end
        mem_ack = 1'b0;
        if (last_p >= 5) last_addr = addr;
        if (last_p >= 6) begin
            last_we = we;
            if (we) last_wdata = wdata;
        end else if (last_p == 5) begin
            last_we = 1'b0;
        end
        if (we && wr_ack_ph < 0 && last_p == 10) m_err = 1'b1;
        if (last_p == rst_ph) begin
            last_addr  = '0;
            last_wdata = '0;
            last_we    = 1'b0;
            m_err      = 1'b0;
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        frame_sync = 1'b0;
        bus_addr   = 8'h00;
        bus_wdata  = 8'h00;
        mem_rdata  = 32'h0;
        mem_ack    = 1'b0;
        m_err      = 1'b0;
        last_addr  = '0;
        last_wdata = '0;
        last_we    = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset phase",   32'(phase),        32'h0);
        checkOutput("reset rdata",   32'(bus_rdata),    32'h0);
        checkOutput("reset oe",      32'(bus_rdata_oe), 32'h0);
        checkOutput("reset req",     32'(mem_req),      32'h0);
        checkOutput("reset we",      32'(mem_we),       32'h0);
        checkOutput("reset addr",    mem_addr,          32'h0);
        checkOutput("reset wdata",   mem_wdata,         32'h0);
        checkOutput("reset err",     32'(err),          32'h0);

        // Zero-wait read
        applyStimulus(32'h4030_2010, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1, -1, 0, -1, -1, 1'b0);
        checkOutput("rd addr P5",  snap_addr[5],  32'h4030_2010);
        checkOutput("rd we P5",    snap_we[5],    32'h0);
        checkOutput("rd byte P6",  snap_rdata[6], 32'hEF);
        checkOutput("rd byte P7",  snap_rdata[7], 32'hBE);
        checkOutput("rd byte P8",  snap_rdata[8], 32'hAD);
        checkOutput("rd byte P9",  snap_rdata[9], 32'hDE);
        checkOutput("rd oe P5",    snap_oe[5],    32'h0);
        checkOutput("rd oe P10",   snap_oe[10],   32'h0);
        checkOutput("rd err",      32'(err),      32'h0);

        // Write acked in P8
        applyStimulus(32'h0000_0100, 32'h4433_2211, 32'h0, 1'b1, 1'b1, 8, 0, -1, -1, 1'b0);
        checkOutput("wr we P6",    snap_we[6],    32'h1);
        checkOutput("wr wdata P8", snap_wdata[8], 32'h4433_2211);
        checkOutput("wr req P8",   snap_req[8],   32'h1);
        checkOutput("wr req P9",   snap_req[9],   32'h0);
        checkOutput("wr byte P7",  snap_rdata[7], 32'h00);

        // Read timeout, then err must survive three good frames
        applyStimulus(32'h1234_5678, 32'h0, 32'h0BAD_0BAD, 1'b0, 1'b0, -1, 0, -1, -1, 1'b0);
        checkOutput("to byte P6",  snap_rdata[6], 32'hFF);
        checkOutput("to byte P9",  snap_rdata[9], 32'hFF);
        checkOutput("to err",      32'(err),      32'h1);
        applyStimulus(32'h0000_0004, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b1, -1, 0, -1, -1, 1'b0);
        applyStimulus(32'h0000_0008, 32'h1111_2222, 32'h0102_0304, 1'b1, 1'b1, 7, 0, -1, -1, 1'b0);
        applyStimulus(32'h0000_000C, 32'h0, 32'h8899_AABB, 1'b0, 1'b1, -1, 0, -1, -1, 1'b0);
        checkOutput("to err sticky", 32'(err), 32'h1);

        // Reset mid-write in P7, late ack in the following P0
        applyStimulus(32'hA0B0_C0D0, 32'h0102_0304, 32'h5566_7788, 1'b1, 1'b1, -1, 0, -1, 7, 1'b0);
        checkOutput("rst phase",   32'(phase),   32'h0);
        checkOutput("rst req",     32'(mem_req), 32'h0);
        checkOutput("rst addr",    mem_addr,     32'h0);
        checkOutput("rst err",     32'(err),     32'h0);
        applyStimulus(32'h0000_BEEF, 32'h0, 32'h3141_5926, 1'b0, 1'b1, -1, 0, -1, -1, 1'b1);
        checkOutput("post-rst req P0", snap_req[0],   32'h0);
        checkOutput("post-rst byte",   snap_rdata[8], 32'h41);

        // Resync in P7 during an open write
        applyStimulus(32'h0BAD_F00D, 32'h8765_4321, 32'h1357_9BDF, 1'b1, 1'b1, -1, 0, 7, -1, 1'b0);
        checkOutput("sync phase",  32'(phase),   32'h1);
        checkOutput("sync req",    32'(mem_req), 32'h0);
        checkOutput("sync err",    32'(err),     32'h0);
        applyStimulus(32'h2468_1357, 32'h0, 32'h0F1E_2D3C, 1'b0, 1'b1, -1, 1, -1, -1, 1'b0);
        checkOutput("sync next addr", snap_addr[5],  32'h2468_1357);
        checkOutput("sync next byte", snap_rdata[6], 32'h3C);

        // Write never acked
        applyStimulus(32'h0000_0200, 32'hAABB_CCDD, 32'h9988_7766, 1'b1, 1'b1, -1, 0, -1, -1, 1'b0);
        checkOutput("wto req P10", snap_req[10], 32'h1);
        checkOutput("wto req",     32'(mem_req), 32'h0);
        checkOutput("wto err",     32'(err),     32'h1);
        applyStimulus(32'h0000_0300, 32'h0, 32'h7654_3210, 1'b0, 1'b1, -1, 0, -1, -1, 1'b0);
        checkOutput("wto next req P5",  snap_req[5],   32'h1);
        checkOutput("wto next addr P5", snap_addr[5],  32'h0000_0300);
        checkOutput("wto next we P5",   snap_we[5],    32'h0);
        checkOutput("wto next byte",    snap_rdata[6], 32'h10);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
